// File: rtl/division_sgn.sv
// Parametrised radix-2 restoring divider with signed/unsigned mode and a divide-by-zero flag.
// Result R packs {remainder, quotient}; start/busy/done handshake, one quotient bit per cycle.
module division_sgn #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   D,
  output logic [2*W-1:0] R,
  output logic           busy,
  output logic           done,
  output logic           div_zero
);

  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dmag_q, dmag_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [2*W-1:0] r_q, r_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  logic           a_neg, d_neg;
  logic [W-1:0]   a_mag, d_mag;
  logic [W:0]     shifted, trial;
  logic [W-1:0]   quo_fix, rem_fix;

  // Operand magnitudes and sign bookkeeping at acceptance
  assign a_neg = signed_mode & A[W-1];
  assign d_neg = signed_mode & D[W-1];
  assign a_mag = a_neg ? (W'(0) - A) : A;
  assign d_mag = d_neg ? (W'(0) - D) : D;

  // Trial subtract: remainder < divisor keeps shifted below 2^(W+1), so trial[W] is the sign
  assign shifted = {rem_q, dvd_q[W-1]};
  assign trial   = shifted - {1'b0, dmag_q};

  assign quo_fix = qneg_q ? (W'(0) - dvd_q) : dvd_q;
  assign rem_fix = rneg_q ? (W'(0) - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (D == W'(0)) begin
            r_d    = {A, {W{1'b1}}};
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            dvd_d   = a_mag;
            dmag_d  = d_mag;
            qneg_d  = a_neg ^ d_neg;
            rneg_d  = a_neg;
            rem_d   = W'(0);
            cnt_d   = CW'(0);
            busy_d  = 1'b1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        r_d     = {rem_fix, quo_fix};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_division_sgn.sv
// Bench for division_sgn: W=32 and W=8 instances checked every cycle against a
// transaction-level arithmetic model, plus hand-computed literal cases.
module tb_division_sgn;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] A32 = '0, D32 = '0;
  logic [63:0] R32;
  logic        busy32, done32, dz32;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  A8 = '0, D8 = '0;
  logic [15:0] R8;
  logic        busy8, done8, dz8;

  int n_checks = 0;
  int n_errs   = 0;

  division_sgn #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
    .A(A32), .D(D32), .R(R32), .busy(busy32), .done(done32), .div_zero(dz32)
  );

  division_sgn #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .A(A8), .D(D8), .R(R8), .busy(busy8), .done(done8), .div_zero(dz8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference division: returns {remainder, quotient}, each in a 64-bit lane, masked to w bits
  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] d,
                                           input bit sm, input int w);
    logic [63:0] mask;
    longint sa, sd, q, r;
    mask = (64'd1 << w) - 64'd1;
    if (sm) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sd = longint'(d << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(a & mask);
      sd = longint'(d & mask);
    end
    q = sa / sd;
    r = sa % sd;
    return {64'(r) & mask, 64'(q) & mask};
  endfunction

  // Transaction-level model: an accepted request produces its result W+1 edges later
  bit          model_on = 1'b0;
  int          m32_left = 0, m8_left = 0;
  logic [63:0] m32_res = '0, e32_R = '0;
  logic [15:0] m8_res = '0, e8_R = '0;
  bit          e32_busy = 0, e32_done = 0, e32_dz = 0;
  bit          e8_busy = 0, e8_done = 0, e8_dz = 0;

  always @(posedge clk) begin
    logic [127:0] q;
    if (rst) begin
      model_on = 1'b1;
      m32_left = 0; e32_R = '0; e32_busy = 0; e32_done = 0; e32_dz = 0;
      m8_left  = 0; e8_R  = '0; e8_busy  = 0; e8_done  = 0; e8_dz  = 0;
    end else begin
      e32_done = 0; e32_dz = 0;
      if (m32_left > 0) begin
        m32_left--;
        if (m32_left == 0) begin e32_done = 1; e32_R = m32_res; end
      end else if (start32) begin
        if (D32 == 32'd0) begin
          e32_R = {A32, 32'hFFFF_FFFF}; e32_done = 1; e32_dz = 1;
        end else begin
          q = ref_div({32'd0, A32}, {32'd0, D32}, sm32, 32);
          m32_res = {q[95:64], q[31:0]};
          m32_left = 33;
        end
      end
      e32_busy = (m32_left > 0);

      e8_done = 0; e8_dz = 0;
      if (m8_left > 0) begin
        m8_left--;
        if (m8_left == 0) begin e8_done = 1; e8_R = m8_res; end
      end else if (start8) begin
        if (D8 == 8'd0) begin
          e8_R = {A8, 8'hFF}; e8_done = 1; e8_dz = 1;
        end else begin
          q = ref_div({56'd0, A8}, {56'd0, D8}, sm8, 8);
          m8_res = {q[71:64], q[7:0]};
          m8_left = 9;
        end
      end
      e8_busy = (m8_left > 0);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy32", 128'(busy32), 128'(e32_busy));
      chk("done32", 128'(done32), 128'(e32_done));
      chk("dz32",   128'(dz32),   128'(e32_dz));
      chk("R32",    128'(R32),    128'(e32_R));
      chk("busy8",  128'(busy8),  128'(e8_busy));
      chk("done8",  128'(done8),  128'(e8_done));
      chk("dz8",    128'(dz8),    128'(e8_dz));
      chk("R8",     128'(R8),     128'(e8_R));
    end
  end

  // Called at a negedge; start is sampled at the following posedge (edge 0).
  // Returns at the negedge where done is seen; idx = edge index that raised done.
  task automatic run32(input logic [31:0] a, input logic [31:0] d, input bit sm,
                       output bit hit, output int idx);
    A32 = a; D32 = d; sm32 = sm; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; A32 = $urandom; D32 = $urandom; sm32 = 1'($urandom);
    hit = 0; idx = -1;
    for (int n = 0; n < 60; n++) begin
      if (done32) begin hit = 1; idx = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] d, input bit sm,
                      output bit hit, output int idx);
    A8 = a; D8 = d; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; A8 = 8'($urandom); D8 = 8'($urandom); sm8 = 1'($urandom);
    hit = 0; idx = -1;
    for (int n = 0; n < 30; n++) begin
      if (done8) begin hit = 1; idx = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] d, input bit sm,
                      input logic [31:0] eq, input logic [31:0] er, input bit edz,
                      input int elat, input string nm);
    bit hit;
    int idx;
    run32(a, d, sm, hit, idx);
    chk({nm, "_done_seen"}, 128'(hit), 128'(1));
    chk({nm, "_done_edge"}, 128'(idx), 128'(elat));
    chk({nm, "_R"},         128'(R32), 128'({er, eq}));
    chk({nm, "_div_zero"},  128'(dz32), 128'(edz));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] d, input bit sm,
                     input logic [7:0] eq, input logic [7:0] er, input bit edz,
                     input int elat, input string nm);
    bit hit;
    int idx;
    run8(a, d, sm, hit, idx);
    chk({nm, "_done_seen"}, 128'(hit), 128'(1));
    chk({nm, "_done_edge"}, 128'(idx), 128'(elat));
    chk({nm, "_R"},         128'(R8),  128'({er, eq}));
    chk({nm, "_div_zero"},  128'(dz8), 128'(edz));
  endtask

  initial begin
    int          ndone;
    logic [63:0] rseen;
    bit          hit;
    int          idx;
    logic [31:0] ra, rd;
    logic [7:0]  ra8, rd8;

    repeat (2) @(negedge clk);
    chk("rst_R32",    128'(R32),    128'(0));
    chk("rst_busy32", 128'(busy32), 128'(0));
    chk("rst_done32", 128'(done32), 128'(0));
    chk("rst_dz32",   128'(dz32),   128'(0));
    chk("rst_R8",     128'(R8),     128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned, back-to-back
    op32(32'd100, 32'd3, 1'b0, 32'd33, 32'd1, 1'b0, 33, "u100_3");
    op32(32'd50,  32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 33, "u50_5");
    // Signed and the same patterns unsigned
    op32(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "s_m7_2");
    op32(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s_7_m2");
    op32(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, "u_fff9_2");
    // Corner cases
    op32(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0, "u_dz");
    op32(32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0, "s_dz");
    op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, "s_ovf");

    // start while busy is ignored
    A32 = 32'd100; D32 = 32'd3; sm32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    A32 = 32'd9; D32 = 32'd4; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    ndone = 0; rseen = '0;
    for (int n = 0; n < 45; n++) begin
      if (done32) begin ndone++; rseen = R32; end
      @(negedge clk);
    end
    chk("busy_start_ndone", 128'(ndone), 128'(1));
    chk("busy_start_R",     128'(rseen), 128'({32'd1, 32'd33}));

    // Reset mid-operation
    A32 = 32'd100; D32 = 32'd3; sm32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_R32",    128'(R32),    128'(0));
    chk("midrst_busy32", 128'(busy32), 128'(0));
    chk("midrst_done32", 128'(done32), 128'(0));
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    chk("midrst_ndone", 128'(ndone), 128'(0));
    op32(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 33, "post_rst_50_5");

    // Narrow instance
    op8(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 9, "w8_200_7");
    op8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9, "w8_ovf");
    op8(8'h5A, 8'h00, 1'b1, 8'hFF, 8'h5A, 1'b1, 0, "w8_dz");
    op8(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9, "w8_m7_2");

    // Randomised W=32: results checked by the per-cycle model comparison
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rd = 32'd0;
        1:       rd = 32'($urandom_range(1, 15));
        2:       rd = 32'hFFFF_FFFF;
        3:       rd = ra;
        4:       rd = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rd = $urandom >> $urandom_range(0, 31);
      endcase
      run32(ra, rd, 1'($urandom), hit, idx);
      chk("rand32_done_seen", 128'(hit), 128'(1));
      chk("rand32_done_edge", 128'(idx), 128'((rd == 32'd0) ? 0 : 33));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Randomised W=8
    for (int i = 0; i < 300; i++) begin
      ra8 = 8'($urandom);
      rd8 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run8(ra8, rd8, 1'($urandom), hit, idx);
      chk("rand8_done_seen", 128'(hit), 128'(1));
      chk("rand8_done_edge", 128'(idx), 128'((rd8 == 8'd0) ? 0 : 9));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
